ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the CPU/IO side to the keyboard.
- Sits beside the keyboard receiver in the IO block and shares the open-drain ps2_clk/ps2_data pins.
- While `busy` is high, the receiver must ignore line activity.

Parameters:
- INHIBIT_CYCLES, 5000, sys_clk cycles the clock line is held low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000, max sys_clk cycles from clock release to ACK complete (20 ms at 50 MHz).

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; accepted when tx_valid && tx_ready.
- tx_ready  out  1  idle, able to accept.
- tx_done  out  1  one-cycle pulse: byte sent and ACK (data low) seen.
- tx_err  out  1  one-cycle pulse: timeout or missing ACK.
- busy  out  1  transfer in progress (state != IDLE).
- ps2_clk_in  in  1  raw clock pin level.
- ps2_data_in  in  1  raw data pin level.
- ps2_clk_oe  out  1  1 = drive clock pin low, 0 = release.
- ps2_data_oe  out  1  1 = drive data pin low, 0 = release.

Behaviour:
- **Reset (rst=0, async):**
  - Outputs: clk_oe=0, data_oe=0, tx_ready=1, busy=0, tx_done=0, tx_err=0; state=IDLE.
  - Reset mid-transfer releases both lines immediately, without waiting for a clock edge.
- **Input sync:**
  - ps2_clk_in and ps2_data_in each pass through a 2-FF synchroniser.
  - fall = sync_clk_prev & ~sync_clk.
  - Detection lag is 2-3 cycles after the pin edge.
- **Handshake:**
  - On accept, tx_data is latched and the state goes to INHIBIT on the next edge; tx_ready=0 from that cycle.
  - tx_valid while busy is ignored.
  - The shift register holds {parity, data}, with parity = ~^data (odd parity).
- **FSM:**
  - IDLE: clk_oe=0, data_oe=0, tx_ready=1.
  - INHIBIT:
    - clk_oe=1 for exactly INHIBIT_CYCLES cycles.
    - data_oe=1 asserted in the last cycle of INHIBIT (start bit).
    - Then -> REQ.
  - REQ:
    - clk_oe=0; data_oe stays 1.
    - The timeout counter clears and starts.
    - bit_cnt=0.
  - SEND (entered from REQ on the first fall; REQ and SEND act on every fall):
    - Each fall increments bit_cnt.
    - bit_cnt 1..8: data_oe = ~data[bit_cnt-1], LSB first.
    - bit_cnt 9: data_oe = ~parity.
    - bit_cnt 10: data_oe=0 (stop bit, released) -> ACK.
  - data_oe updates in the cycle after fall is detected.
  - ACK: on the next fall, sample sync_data.
    - 0 -> WAIT_IDLE.
    - 1 -> tx_err pulse, go to IDLE.
  - WAIT_IDLE: when sync_clk=1 and sync_data=1 -> tx_done pulse, go to IDLE.
- **Timeout:**
  - The counter runs in REQ, SEND, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES: both oe=0, tx_err pulse, go to IDLE. The timeout has priority over a simultaneous fall.
- **Pulses:** tx_done and tx_err are never both high; each lasts one cycle.
- **Back-to-back:** tx_ready returns to 1 in the cycle after done/err, so the next accept is possible one cycle later.
- **Counter width:** $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1); counters saturate and never wrap.

Decomposition:
- **ps2_pkg:**
  - State enum (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE).
  - Command constants: CMD_SET_LED=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF, ACK_BYTE=8'hFA.
  - Frame length constant 11.
- **Sub-module ps2_sync_edge:**
  - 2-FF sync of clk/data plus falling-edge strobe.
  - Reused by the keyboard receiver.

Test Plan:
- **Reset:** rst=0 during SEND at bit 4 -> clk_oe=0 and data_oe=0 in the same cycle; after release, tx_ready=1.
- **Send 0xED:** device model clocks at 12 kHz and ACKs.
  - Sampled host bits at rising edges: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - clk_oe low for exactly 5000 cycles.
  - tx_done pulses once.
- **Send 0x01:**
  - Parity bit sampled 0; 0x00 -> parity 1.
  - tx_done pulses once.
- **No ACK:** device leaves data high at the 11th clock -> tx_err=1 for one cycle, tx_done never asserts, state IDLE.
- **Silent device:** no clocks after REQ -> tx_err exactly TIMEOUT_CYCLES cycles after clock release; both oe=0.
- **Busy handling:**
  - tx_valid held high with 0x55 while busy -> ignored.
  - A second request is accepted one cycle after tx_done, and the frame is correct.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, common keyboard command bytes, frame size.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] ACK_BYTE    = 8'hFA;

  // start + 8 data + parity + stop
  localparam int unsigned FRAME_LEN = 11;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for the PS/2 clock and data pins plus a clock falling-edge strobe.
// Latency: levels appear 2 cycles after the pin, fall strobe 2-3 cycles after the pin edge.
// Backpressure: none; free-running sampler.
module ps2_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic sync_clk_o,
  output logic sync_data_o,
  output logic fall_o
);

  logic [1:0] clk_ff_q;
  logic [1:0] data_ff_q;
  logic       clk_prev_q;

  // Resync both pins; reset to the idle-high bus level so no false edge follows reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_ff_q   <= 2'b11;
      data_ff_q  <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_ff_q   <= {clk_ff_q[0], ps2_clk_i};
      data_ff_q  <= {data_ff_q[0], ps2_data_i};
      clk_prev_q <= clk_ff_q[1];
    end
  end

  assign sync_clk_o  = clk_ff_q[1];
  assign sync_data_o = data_ff_q[1];
  assign fall_o      = clk_prev_q & ~clk_ff_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift 10 bits on device clock falls, check ACK.
// Latency: INHIBIT_CYCLES of clock inhibit, then paced by the device clock; done/err pulse after ACK/timeout.
// Backpressure: tx_ready only in IDLE; tx_valid is ignored while busy.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,   // must be >= 2
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CNT_TOP = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CW = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] CNT_SAT      = {CW{1'b1}};
  localparam logic [CW-1:0] INH_LAST     = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_START    = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] TO_LAST      = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_SHIFTED = 4'(FRAME_LEN - 2);

  ps2_state_e     state_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_inc_d;
  logic [3:0]     bit_cnt_q;
  logic [8:0]     shift_q;
  logic           clk_oe_q;
  logic           data_oe_q;
  logic           done_q;
  logic           err_q;

  logic           sync_clk;
  logic           sync_data;
  logic           clk_fall;

  ps2_sync_edge u_sync (
    .clk_i       (sys_clk),
    .rst_ni      (rst),
    .ps2_clk_i   (ps2_clk_in),
    .ps2_data_i  (ps2_data_in),
    .sync_clk_o  (sync_clk),
    .sync_data_o (sync_data),
    .fall_o      (clk_fall)
  );

  // Shared inhibit/timeout counter increments but sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_inc_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
  end

  // Transfer FSM with registered pin enables and result pulses.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_valid) begin
            shift_q   <= {odd_parity(tx_data), tx_data};
            cnt_q     <= '0;
            clk_oe_q  <= 1'b1;
            data_oe_q <= 1'b0;
            state_q   <= INHIBIT;
          end
        end
        INHIBIT: begin
          cnt_q <= cnt_inc_d;
          // start bit goes low in the final inhibit cycle
          if (cnt_q == INH_START) begin
            data_oe_q <= 1'b1;
          end
          if (cnt_q == INH_LAST) begin
            clk_oe_q  <= 1'b0;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= REQ;
          end
        end
        default: begin
          // timeout wins over any clock fall seen in the same cycle
          if (cnt_q >= TO_LAST) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_inc_d;
            case (state_q)
              REQ, SEND: begin
                if (clk_fall) begin
                  // LSB first; ones shifted in make the 10th bit a released (high) stop bit
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  data_oe_q <= ~shift_q[0];
                  shift_q   <= {1'b1, shift_q[8:1]};
                  state_q   <= (bit_cnt_q == LAST_SHIFTED) ? ACK : SEND;
                end
              end
              ACK: begin
                if (clk_fall) begin
                  if (sync_data) begin
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                  end else begin
                    state_q <= WAIT_IDLE;
                  end
                end
              end
              WAIT_IDLE: begin
                if (sync_clk && sync_data) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
                end
              end
              default: begin
              end
            endcase
          end
        end
      endcase
    end
  end

  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
